bcd_display_scan: RTL and testbench

BCD_DISPLAY_SCAN -- requirements
Module: bcd_display_scan

---
 rtl/bcd_display_scan.sv | 146 ++++++++++++++
 tb/tb_bcd_display_scan.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/bcd_display_scan.sv
// Two-digit multiplexed 7-segment scanner with blanking dead time and sticky overflow dp.
// Define LEADING_ZERO_BLANK_EN to blank a zero tens digit.
module bcd_display_scan #(
    parameter int unsigned PRESCALE = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] digit_1,
    input  logic [3:0] digit_10,
    input  logic       carry,
    input  logic       ovf_clr,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic       dp,
    output logic       frame
);

    typedef enum logic [1:0] {
        S_D1  = 2'd0,
        S_B1  = 2'd1,
        S_D10 = 2'd2,
        S_B10 = 2'd3
    } state_t;

    localparam logic [15:0] PRE_MAX = 16'(PRESCALE - 1);
    localparam logic [6:0]  SEG_OFF = 7'h7F;

    logic [15:0] pre_q, pre_d;
    logic        tick;
    state_t      state_q, state_d;
    logic [3:0]  sh1_q, sh1_d;
    logic [3:0]  sh10_q, sh10_d;
    logic        snap_q, snap_d;
    logic        ovf_q, ovf_d;
    logic [6:0]  seg_q, seg_d;
    logic [1:0]  an_q, an_d;
    logic        dp_q, dp_d;
    logic        frame_q, frame_d;

    function automatic logic [6:0] dec7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h3F;
        endcase
        return s;
    endfunction

    always_comb begin
        tick  = (pre_q == PRE_MAX);
        pre_d = tick ? 16'd0 : pre_q + 16'd1;
    end

    always_comb begin
        state_d = state_q;
        if (tick) begin
            unique case (state_q)
                S_D1:    state_d = S_B1;
                S_B1:    state_d = S_D10;
                S_D10:   state_d = S_B10;
                default: state_d = S_D1;
            endcase
        end
    end

    // Inputs are sampled only when the scan wraps back to the units digit.
    always_comb begin
        snap_d = tick && (state_q == S_B10);
        sh1_d  = snap_d ? digit_1  : sh1_q;
        sh10_d = snap_d ? digit_10 : sh10_q;
    end

    // carry has priority over the clear.
    always_comb begin
        ovf_d = ovf_q;
        if (ovf_clr) ovf_d = 1'b0;
        if (carry)   ovf_d = 1'b1;
    end

    always_comb begin
        seg_d   = SEG_OFF;
        an_d    = 2'b11;
        dp_d    = 1'b1;
        frame_d = snap_q;
        unique case (state_q)
            S_D1: begin
                an_d  = 2'b10;
                seg_d = dec7(sh1_q);
            end
            S_D10: begin
                an_d  = 2'b01;
                dp_d  = ~ovf_q;
`ifdef LEADING_ZERO_BLANK_EN
                seg_d = (sh10_q == 4'd0) ? SEG_OFF : dec7(sh10_q);
`else
                seg_d = dec7(sh10_q);
`endif
            end
            default: begin
                seg_d = SEG_OFF;
                an_d  = 2'b11;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pre_q   <= 16'd0;
            state_q <= S_B10;
            sh1_q   <= 4'd0;
            sh10_q  <= 4'd0;
            snap_q  <= 1'b0;
            ovf_q   <= 1'b0;
            seg_q   <= SEG_OFF;
            an_q    <= 2'b11;
            dp_q    <= 1'b1;
            frame_q <= 1'b0;
        end else begin
            pre_q   <= pre_d;
            state_q <= state_d;
            sh1_q   <= sh1_d;
            sh10_q  <= sh10_d;
            snap_q  <= snap_d;
            ovf_q   <= ovf_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
            dp_q    <= dp_d;
            frame_q <= frame_d;
        end
    end

    assign seg   = seg_q;
    assign an    = an_q;
    assign dp    = dp_q;
    assign frame = frame_q;

endmodule

// File: tb/tb_bcd_display_scan.sv
// Directed bench for bcd_display_scan at PRESCALE=4.
// Define LEADING_ZERO_BLANK_EN to match the DUT build.
module tb_bcd_display_scan;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] digit_1 = 4'd0;
    logic [3:0] digit_10 = 4'd0;
    logic       carry = 1'b0;
    logic       ovf_clr = 1'b0;
    logic [6:0] seg;
    logic [1:0] an;
    logic       dp;
    logic       frame;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    bcd_display_scan #(.PRESCALE(4)) dut (
        .clk(clk), .reset(reset),
        .digit_1(digit_1), .digit_10(digit_10),
        .carry(carry), .ovf_clr(ovf_clr),
        .seg(seg), .an(an), .dp(dp), .frame(frame)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) step();
    endtask

    task automatic release_rst();
        @(negedge clk);
        reset = 1'b1;
        cyc = 0;
    endtask

    initial begin
        digit_1  = 4'd3;
        digit_10 = 4'd7;
        repeat (2) @(negedge clk);
        chk("rst_seg", 32'(seg), 32'h7F);
        chk("rst_an", 32'(an), 32'h3);
        chk("rst_dp", 32'(dp), 32'h1);
        chk("rst_frame", 32'(frame), 32'h0);

        release_rst();
        run_to(4);
        chk("f4", 32'(frame), 32'h0);
        chk("seg4", 32'(seg), 32'h7F);
        run_to(5);
        chk("f5", 32'(frame), 32'h1);
        chk("seg5", 32'(seg), 32'h30);
        chk("an5", 32'(an), 32'h2);
        digit_1  = 4'd9;
        digit_10 = 4'd2;
        run_to(6);
        chk("f6", 32'(frame), 32'h0);
        run_to(8);
        chk("seg8", 32'(seg), 32'h30);
        run_to(9);
        chk("seg9", 32'(seg), 32'h7F);
        chk("an9", 32'(an), 32'h3);
        run_to(12);
        chk("seg12", 32'(seg), 32'h7F);
        run_to(13);
        chk("seg13", 32'(seg), 32'h78);
        chk("an13", 32'(an), 32'h1);
        chk("dp13", 32'(dp), 32'h1);
        run_to(16);
        chk("seg16", 32'(seg), 32'h78);
        run_to(20);
        chk("f20", 32'(frame), 32'h0);
        run_to(21);
        chk("f21", 32'(frame), 32'h1);
        chk("seg21", 32'(seg), 32'h10);
        run_to(29);
        chk("seg29", 32'(seg), 32'h24);
        chk("an29", 32'(an), 32'h1);

        run_to(30);
        digit_10 = 4'hC;
        run_to(40);
        carry = 1'b1;
        step();
        carry = 1'b0;
        run_to(44);
        chk("dp44", 32'(dp), 32'h1);
        run_to(45);
        chk("seg45", 32'(seg), 32'h3F);
        chk("dp45", 32'(dp), 32'h0);
        run_to(48);
        chk("dp48", 32'(dp), 32'h0);
        run_to(49);
        chk("dp49", 32'(dp), 32'h1);
        run_to(61);
        chk("dp61", 32'(dp), 32'h0);
        run_to(65);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        run_to(77);
        chk("dp77", 32'(dp), 32'h1);
        run_to(81);
        carry   = 1'b1;
        ovf_clr = 1'b1;
        step();
        carry   = 1'b0;
        ovf_clr = 1'b0;
        run_to(93);
        chk("dp93", 32'(dp), 32'h0);
        chk("an93", 32'(an), 32'h1);

        run_to(94);
        digit_1  = 4'd5;
        digit_10 = 4'd0;
        run_to(101);
        chk("f101", 32'(frame), 32'h1);
        chk("seg101", 32'(seg), 32'h12);
        run_to(109);
        chk("an109", 32'(an), 32'h1);
        chk("dp109", 32'(dp), 32'h0);
`ifdef LEADING_ZERO_BLANK_EN
        chk("seg109", 32'(seg), 32'h7F);
`else
        chk("seg109", 32'(seg), 32'h40);
`endif

        run_to(110);
        reset = 1'b0;
        #1;
        chk("arst_seg", 32'(seg), 32'h7F);
        chk("arst_an", 32'(an), 32'h3);
        chk("arst_dp", 32'(dp), 32'h1);
        repeat (2) @(negedge clk);
        release_rst();
        run_to(4);
        chk("r_f4", 32'(frame), 32'h0);
        run_to(5);
        chk("r_f5", 32'(frame), 32'h1);
        chk("r_seg5", 32'(seg), 32'h12);
        run_to(13);
        chk("r_dp13", 32'(dp), 32'h1);
        chk("r_an13", 32'(an), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
